// File: rtl/dct_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the DCT block arbiter.
package dct_pkg;

  localparam int DCT_BLK_BEATS = 64;
  localparam int DCT_LAST_BEAT = 63;
  localparam int BEAT_W        = $clog2(DCT_BLK_BEATS);

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index that follows idx in a ring of num_ch requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ch);
    return (idx + 32'd1 >= num_ch) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/dct_tag_fifo.sv
// Synchronous FIFO holding the channel ID of every block in flight inside the DCT core.
module dct_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dct_block_arbiter.sv
// Block-granular round-robin arbiter sharing one 8x8 DCT core between NUM_CH pixel streams.
// Optional DCT_ARB_STATS_EN adds per-channel completed-block counters on blk_cnt.
module dct_block_arbiter
  import dct_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int CH_W         = 2,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tready,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  output logic                          core_s_tvalid,
  input  logic                          core_s_tready,
  output logic [INPUT_WIDTH-1:0]        core_s_tdata,
  output logic                          core_s_tlast,
  input  logic                          core_m_tvalid,
  output logic                          core_m_tready,
  input  logic [OUTPUT_WIDTH-1:0]       core_m_tdata,
  input  logic                          core_m_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [OUTPUT_WIDTH-1:0]       m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [CH_W-1:0]               m_axis_tdest,
  output logic                          framing_err,
  output logic                          busy
`ifdef DCT_ARB_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]          blk_cnt
`endif
);

  // Handshake: a beat moves on a port only in a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready on the core side of this block.

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              framing_err_q, framing_err_d;

  logic              found;
  logic [CH_W-1:0]   pick;
  logic              gnt_valid;
  logic              gnt_last;
  logic              in_hs;
  logic              last_beat;
  logic              tag_push;
  logic              tag_pop;
  logic              tag_full;
  logic              tag_empty;
  logic [CH_W-1:0]   tag_head;

  // Search rr_ptr..NUM_CH-1 first, then wrap to 0..rr_ptr-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && s_axis_tvalid[i] && (CH_W'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        pick  = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && s_axis_tvalid[i]) begin
        found = 1'b1;
        pick  = CH_W'(i);
      end
    end
  end

  always_comb begin
    gnt_valid     = 1'b0;
    gnt_last      = 1'b0;
    core_s_tdata  = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q == CH_W'(i)) begin
        gnt_valid    = s_axis_tvalid[i];
        gnt_last     = s_axis_tlast[i];
        core_s_tdata = s_axis_tdata[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
    if (state_q == ARB_GRANT) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s_axis_tready[i] = (gnt_q == CH_W'(i)) && core_s_tready;
      end
    end
  end

  assign last_beat     = (beat_cnt_q == BEAT_W'(DCT_LAST_BEAT));
  assign core_s_tvalid = (state_q == ARB_GRANT) && gnt_valid;
  assign core_s_tlast  = (state_q == ARB_GRANT) && last_beat;
  assign in_hs         = core_s_tvalid && core_s_tready;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    framing_err_d = framing_err_q;
    tag_push      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found && !tag_full) begin
          gnt_d    = pick;
          tag_push = 1'b1;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (in_hs) begin
          // The block length is fixed; input tlast is only cross-checked.
          if (gnt_last != last_beat) framing_err_d = 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            rr_ptr_d   = CH_W'(rr_next(32'(gnt_q), NUM_CH));
            state_d    = ARB_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (core_m_tvalid && tag_empty) framing_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      framing_err_q <= framing_err_d;
    end
  end

  dct_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (gnt_d),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Coefficients without a tag have no owner and are suppressed.
  assign m_axis_tvalid = core_m_tvalid && !tag_empty;
  assign m_axis_tdata  = core_m_tdata;
  assign m_axis_tlast  = core_m_tlast;
  assign m_axis_tdest  = tag_head;
  assign core_m_tready = m_axis_tready;
  assign tag_pop       = core_m_tvalid && m_axis_tready && core_m_tlast && !tag_empty;

  assign framing_err   = framing_err_q;
  assign busy          = (state_q == ARB_GRANT) || !tag_empty;

`ifdef DCT_ARB_STATS_EN
  logic [15:0] blk_cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) blk_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tag_pop && (tag_head == CH_W'(i))) blk_cnt_q[i] <= blk_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    blk_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) blk_cnt[i*16 +: 16] = blk_cnt_q[i];
  end
`endif

endmodule
